// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and helpers for the pipeline hazard controller
package pipe_pkg;

    localparam int RA_W_DEFAULT = 5;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef struct packed {
        logic                    valid;
        logic [RA_W_DEFAULT-1:0] rd;
        logic                    we;
        logic                    is_load;
        logic [RA_W_DEFAULT-1:0] rs1;
        logic [RA_W_DEFAULT-1:0] rs2;
        logic                    rs1_used;
        logic                    rs2_used;
    } shadow_t;

    // A producer only counts when it really writes a non-zero register the consumer reads.
    function automatic logic src_match(shadow_t p, logic [RA_W_DEFAULT-1:0] rs, logic used);
        return p.valid && p.we && used && (rs == p.rd) && (rs != '0);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - ID/EX hazard inputs and pipeline control outputs
interface pipe_hazard_ctrl_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 32
) ();
    logic            id_valid;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic            id_rs1_used;
    logic            id_rs2_used;
    logic [RA_W-1:0] id_rd;
    logic            id_rf_we;
    logic            id_is_load;
    logic            ex_redirect;

    logic             pc_hold;
    logic             if_id_hold;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic [1:0]       ex_fwd_a;
    logic [1:0]       ex_fwd_b;
    logic             wb_valid;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rf_we, id_is_load, ex_redirect,
        input  pc_hold, if_id_hold, if_id_flush, id_ex_bubble,
               ex_fwd_a, ex_fwd_b, wb_valid, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rf_we, id_is_load, ex_redirect,
        output pc_hold, if_id_hold, if_id_flush, id_ex_bubble,
               ex_fwd_a, ex_fwd_b, wb_valid, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_stage_reg.sv
// rtl/hazard_stage_reg.sv - one shadow entry tracking an in-flight instruction
module hazard_stage_reg
    import pipe_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  logic    bubble,
    input  shadow_t d,
    output shadow_t q
);

    // A bubble clears the whole entry so stale register fields can never match.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/forward control for the 5-stage pipeline; HAZ_FWD_EN enables forwarding
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int RA_W  = RA_W_DEFAULT,
    parameter int CNT_W = 32
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    pipe_hazard_ctrl_if.slave hz
);

    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic [RA_W-1:0] id_rd;
    shadow_t         id_entry;
    shadow_t         ex_q;
    shadow_t         mem_q;
    shadow_t         wb_q;
    logic            stall_raw;
    logic            stall;
    logic            redirect;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    assign id_rs1 = hz.id_rs1;
    assign id_rs2 = hz.id_rs2;
    assign id_rd  = hz.id_rd;

    always_comb begin
        id_entry          = '0;
        id_entry.valid    = hz.id_valid;
        id_entry.rd       = RA_W_DEFAULT'(id_rd);
        id_entry.we       = hz.id_rf_we;
        id_entry.is_load  = hz.id_is_load;
        id_entry.rs1      = RA_W_DEFAULT'(id_rs1);
        id_entry.rs2      = RA_W_DEFAULT'(id_rs2);
        id_entry.rs1_used = hz.id_rs1_used;
        id_entry.rs2_used = hz.id_rs2_used;
    end

    hazard_stage_reg u_ex (
        .clk    (cpu_clk),
        .rst    (cpu_rst),
        .load   (1'b1),
        .bubble (hz.id_ex_bubble),
        .d      (id_entry),
        .q      (ex_q)
    );

    hazard_stage_reg u_mem (
        .clk    (cpu_clk),
        .rst    (cpu_rst),
        .load   (1'b1),
        .bubble (1'b0),
        .d      (ex_q),
        .q      (mem_q)
    );

    hazard_stage_reg u_wb (
        .clk    (cpu_clk),
        .rst    (cpu_rst),
        .load   (1'b1),
        .bubble (1'b0),
        .d      (mem_q),
        .q      (wb_q)
    );

`ifdef HAZ_FWD_EN
    // Only a load still in EX cannot be forwarded in time; everything else comes off MEM or WB.
    always_comb begin
        stall_raw = hz.id_valid && ex_q.is_load &&
                    (src_match(ex_q, id_entry.rs1, id_entry.rs1_used) ||
                     src_match(ex_q, id_entry.rs2, id_entry.rs2_used));
        fwd_a = FWD_RF;
        if (src_match(mem_q, ex_q.rs1, ex_q.rs1_used))     fwd_a = FWD_MEM;
        else if (src_match(wb_q, ex_q.rs1, ex_q.rs1_used)) fwd_a = FWD_WB;
        fwd_b = FWD_RF;
        if (src_match(mem_q, ex_q.rs2, ex_q.rs2_used))     fwd_b = FWD_MEM;
        else if (src_match(wb_q, ex_q.rs2, ex_q.rs2_used)) fwd_b = FWD_WB;
    end
`else
    // WB needs no check: the register file returns the value being written in the same cycle.
    always_comb begin
        stall_raw = hz.id_valid &&
                    (src_match(ex_q,  id_entry.rs1, id_entry.rs1_used) ||
                     src_match(ex_q,  id_entry.rs2, id_entry.rs2_used) ||
                     src_match(mem_q, id_entry.rs1, id_entry.rs1_used) ||
                     src_match(mem_q, id_entry.rs2, id_entry.rs2_used));
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
    end
`endif

    // Redirect discards the ID instruction, so a coincident stall is moot.
    assign redirect = hz.ex_redirect && !cpu_rst;
    assign stall    = stall_raw && !hz.ex_redirect && !cpu_rst;

    assign hz.pc_hold      = stall;
    assign hz.if_id_hold   = stall;
    assign hz.if_id_flush  = redirect;
    assign hz.id_ex_bubble = stall || redirect;
    assign hz.ex_fwd_a     = fwd_a;
    assign hz.ex_fwd_b     = fwd_b;
    assign hz.wb_valid     = wb_q.valid;
    assign hz.stall_cnt    = stall_q;
    assign hz.flush_cnt    = flush_q;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall && !(&stall_q))    stall_q <= stall_q + 1'b1;
            if (redirect && !(&flush_q)) flush_q <= flush_q + 1'b1;
        end
    end

    logic unused_shadow;
    assign unused_shadow = ^{ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl against an instruction-level model
module tb_pipe_hazard_ctrl;

    localparam int RA_W  = 5;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef HAZ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic cpu_clk = 1'b0;
    logic cpu_rst = 1'b1;
    always #5 cpu_clk = ~cpu_clk;

    pipe_hazard_ctrl_if #(.RA_W(RA_W), .CNT_W(CNT_W)) hz ();

    pipe_hazard_ctrl #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .hz      (hz)
    );

    typedef struct {
        bit v;
        int rd;
        int rs1;
        int rs2;
        bit u1;
        bit u2;
        bit we;
        bit ld;
        int tag;
    } instr_t;

    int total = 0;
    int bad   = 0;

    instr_t m_ex, m_mem, m_wb;
    int     m_scnt, m_fcnt;
    instr_t prog[$];
    logic [1:0] obs_fa[int];
    logic [1:0] obs_fb[int];
    int     obs_holds;

    function automatic instr_t nop();
        instr_t n;
        n.v = 0; n.rd = 0; n.rs1 = 0; n.rs2 = 0;
        n.u1 = 0; n.u2 = 0; n.we = 0; n.ld = 0; n.tag = 0;
        return n;
    endfunction

    function automatic instr_t mk(int tag, int rd, bit we, bit ld, int rs1, bit u1, int rs2, bit u2);
        instr_t n;
        n.v = 1; n.tag = tag; n.rd = rd; n.we = we; n.ld = ld;
        n.rs1 = rs1; n.u1 = u1; n.rs2 = rs2; n.u2 = u2;
        return n;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t n;
        n = nop();
        if ($urandom_range(0, 9) < 8) begin
            n.v   = 1;
            n.rd  = $urandom_range(0, 3);
            n.ld  = ($urandom_range(0, 3) == 0);
            n.we  = n.ld || ($urandom_range(0, 4) != 0);
            n.rs1 = $urandom_range(0, 3);
            n.rs2 = $urandom_range(0, 3);
            n.u1  = ($urandom_range(0, 9) < 7);
            n.u2  = ($urandom_range(0, 9) < 7);
        end
        return n;
    endfunction

    // A producer that is still in flight and writes a non-zero register the reader uses.
    function automatic bit writes_for(instr_t p, int rs, bit used);
        return p.v && p.we && used && rs != 0 && rs == p.rd;
    endfunction

    function automatic logic [1:0] want_sel(int rs, bit used);
        if (!FWD) return 2'd0;
        if (writes_for(m_mem, rs, used)) return 2'd1;
        if (writes_for(m_wb, rs, used)) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_clear();
        m_ex = nop(); m_mem = nop(); m_wb = nop();
        m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic drive_id(input instr_t id, input bit redir);
        hz.id_valid    = id.v;
        hz.id_rd       = RA_W'(id.rd);
        hz.id_rs1      = RA_W'(id.rs1);
        hz.id_rs2      = RA_W'(id.rs2);
        hz.id_rs1_used = id.u1;
        hz.id_rs2_used = id.u2;
        hz.id_rf_we    = id.we;
        hz.id_is_load  = id.ld;
        hz.ex_redirect = redir;
    endtask

    task automatic do_reset();
        cpu_rst = 1'b1;
        drive_id(nop(), 1'b0);
        @(posedge cpu_clk);
        #1;
        model_clear();
        cpu_rst = 1'b0;
    endtask

    task automatic run_cycle(input instr_t id, input bit redir, output bit stalled, output bit held);
        bit haz, e_stall;
        logic [1:0] e_fa, e_fb;
        drive_id(id, redir);
        #1;
        if (FWD)
            haz = id.v && m_ex.ld && (writes_for(m_ex, id.rs1, id.u1) || writes_for(m_ex, id.rs2, id.u2));
        else
            haz = id.v && (writes_for(m_ex, id.rs1, id.u1) || writes_for(m_ex, id.rs2, id.u2) ||
                           writes_for(m_mem, id.rs1, id.u1) || writes_for(m_mem, id.rs2, id.u2));
        e_stall = haz && !redir;
        e_fa = want_sel(m_ex.rs1, m_ex.u1);
        e_fb = want_sel(m_ex.rs2, m_ex.u2);
        total += 9;
        if (hz.pc_hold !== e_stall) begin bad++; $display("FAIL pc_hold t=%0t got %b want %b", $time, hz.pc_hold, e_stall); end
        if (hz.if_id_hold !== e_stall) begin bad++; $display("FAIL if_id_hold t=%0t got %b want %b", $time, hz.if_id_hold, e_stall); end
        if (hz.if_id_flush !== redir) begin bad++; $display("FAIL if_id_flush t=%0t got %b want %b", $time, hz.if_id_flush, redir); end
        if (hz.id_ex_bubble !== (e_stall || redir)) begin bad++; $display("FAIL id_ex_bubble t=%0t got %b want %b", $time, hz.id_ex_bubble, e_stall || redir); end
        if (hz.ex_fwd_a !== e_fa) begin bad++; $display("FAIL ex_fwd_a t=%0t got %0d want %0d", $time, hz.ex_fwd_a, e_fa); end
        if (hz.ex_fwd_b !== e_fb) begin bad++; $display("FAIL ex_fwd_b t=%0t got %0d want %0d", $time, hz.ex_fwd_b, e_fb); end
        if (hz.wb_valid !== m_wb.v) begin bad++; $display("FAIL wb_valid t=%0t got %b want %b", $time, hz.wb_valid, m_wb.v); end
        if (hz.stall_cnt !== CNT_W'(m_scnt)) begin bad++; $display("FAIL stall_cnt t=%0t got %0d want %0d", $time, hz.stall_cnt, m_scnt); end
        if (hz.flush_cnt !== CNT_W'(m_fcnt)) begin bad++; $display("FAIL flush_cnt t=%0t got %0d want %0d", $time, hz.flush_cnt, m_fcnt); end
        stalled = e_stall;
        held    = hz.pc_hold;
        @(posedge cpu_clk);
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = (e_stall || redir) ? nop() : id;
        if (e_stall && m_scnt < CMAX) m_scnt++;
        if (redir && m_fcnt < CMAX) m_fcnt++;
        #1;
    endtask

    task automatic run_prog(input int ncyc);
        bit st, held;
        instr_t id;
        obs_fa.delete();
        obs_fb.delete();
        obs_holds = 0;
        for (int i = 0; i < ncyc; i++) begin
            id = (prog.size() != 0) ? prog[0] : nop();
            run_cycle(id, 1'b0, st, held);
            if (held) obs_holds++;
            if (!st && prog.size() != 0) void'(prog.pop_front());
            if (m_ex.v) begin
                obs_fa[m_ex.tag] = hz.ex_fwd_a;
                obs_fb[m_ex.tag] = hz.ex_fwd_b;
            end
        end
    endtask

    function automatic logic [1:0] seen_a(int tag);
        return obs_fa.exists(tag) ? obs_fa[tag] : 2'd3;
    endfunction

    function automatic logic [1:0] seen_b(int tag);
        return obs_fb.exists(tag) ? obs_fb[tag] : 2'd3;
    endfunction

    task automatic test_reset();
        do_reset();
        #1;
        total += 5;
        if ({hz.pc_hold, hz.if_id_hold, hz.if_id_flush, hz.id_ex_bubble} !== 4'b0) begin
            bad++; $display("FAIL reset_ctl got %b want 0000", {hz.pc_hold, hz.if_id_hold, hz.if_id_flush, hz.id_ex_bubble});
        end
        if ({hz.ex_fwd_a, hz.ex_fwd_b} !== 4'b0) begin bad++; $display("FAIL reset_fwd got %b want 0000", {hz.ex_fwd_a, hz.ex_fwd_b}); end
        if (hz.wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid got %b want 0", hz.wb_valid); end
        if (hz.stall_cnt !== '0) begin bad++; $display("FAIL reset_stall_cnt got %0d want 0", hz.stall_cnt); end
        if (hz.flush_cnt !== '0) begin bad++; $display("FAIL reset_flush_cnt got %0d want 0", hz.flush_cnt); end
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic test_raw_alu();
        do_reset();
        prog = {mk(1, 5, 1, 0, 0, 1, 0, 0), mk(2, 6, 1, 0, 5, 1, 5, 1)};
        run_prog(7);
        total += 4;
        if (hz.stall_cnt !== CNT_W'(FWD ? 0 : 2)) begin bad++; $display("FAIL raw_alu_stall_cnt got %0d want %0d", hz.stall_cnt, FWD ? 0 : 2); end
        if (obs_holds !== (FWD ? 0 : 2)) begin bad++; $display("FAIL raw_alu_holds got %0d want %0d", obs_holds, FWD ? 0 : 2); end
        if (seen_a(2) !== (FWD ? 2'd1 : 2'd0)) begin bad++; $display("FAIL raw_alu_fwd_a got %0d want %0d", seen_a(2), FWD ? 1 : 0); end
        if (seen_b(2) !== (FWD ? 2'd1 : 2'd0)) begin bad++; $display("FAIL raw_alu_fwd_b got %0d want %0d", seen_b(2), FWD ? 1 : 0); end
    endtask

    task automatic test_load_use();
        do_reset();
        prog = {mk(1, 7, 1, 1, 0, 1, 0, 0), mk(2, 8, 1, 0, 7, 1, 0, 1)};
        run_prog(7);
        total += 3;
        if (hz.stall_cnt !== CNT_W'(FWD ? 1 : 2)) begin bad++; $display("FAIL load_use_stall_cnt got %0d want %0d", hz.stall_cnt, FWD ? 1 : 2); end
        if (obs_holds !== (FWD ? 1 : 2)) begin bad++; $display("FAIL load_use_holds got %0d want %0d", obs_holds, FWD ? 1 : 2); end
        if (seen_a(2) !== (FWD ? 2'd2 : 2'd0)) begin bad++; $display("FAIL load_use_fwd_a got %0d want %0d", seen_a(2), FWD ? 2 : 0); end
    endtask

    task automatic test_x0_and_unused();
        do_reset();
        prog = {mk(1, 0, 1, 1, 0, 1, 0, 1), mk(2, 9, 1, 1, 0, 1, 0, 1), mk(3, 10, 1, 0, 9, 0, 9, 0)};
        run_prog(8);
        total += 4;
        if (obs_holds !== 0) begin bad++; $display("FAIL x0_holds got %0d want 0", obs_holds); end
        if (hz.stall_cnt !== '0) begin bad++; $display("FAIL x0_stall_cnt got %0d want 0", hz.stall_cnt); end
        if (seen_a(2) !== 2'd0) begin bad++; $display("FAIL x0_fwd_a got %0d want 0", seen_a(2)); end
        if (seen_a(3) !== 2'd0) begin bad++; $display("FAIL unused_fwd_a got %0d want 0", seen_a(3)); end
    endtask

    task automatic test_redirect_over_stall();
        bit st, held;
        do_reset();
        run_cycle(mk(1, 7, 1, 1, 0, 1, 0, 0), 1'b0, st, held);
        drive_id(mk(2, 8, 1, 0, 7, 1, 0, 1), 1'b1);
        #1;
        total += 6;
        if (hz.pc_hold !== 1'b0) begin bad++; $display("FAIL redir_pc_hold got %b want 0", hz.pc_hold); end
        if (hz.if_id_hold !== 1'b0) begin bad++; $display("FAIL redir_if_id_hold got %b want 0", hz.if_id_hold); end
        if (hz.if_id_flush !== 1'b1) begin bad++; $display("FAIL redir_flush got %b want 1", hz.if_id_flush); end
        if (hz.id_ex_bubble !== 1'b1) begin bad++; $display("FAIL redir_bubble got %b want 1", hz.id_ex_bubble); end
        @(posedge cpu_clk);
        #1;
        drive_id(nop(), 1'b0);
        if (hz.flush_cnt !== CNT_W'(1)) begin bad++; $display("FAIL redir_flush_cnt got %0d want 1", hz.flush_cnt); end
        if (hz.stall_cnt !== '0) begin bad++; $display("FAIL redir_stall_cnt got %0d want 0", hz.stall_cnt); end
    endtask

    task automatic test_double_match();
        do_reset();
        prog = {mk(1, 5, 1, 0, 0, 1, 0, 0), mk(2, 5, 1, 0, 0, 1, 0, 0), mk(3, 6, 1, 0, 5, 1, 0, 1)};
        run_prog(9);
        total += 2;
        if (seen_a(3) !== (FWD ? 2'd1 : 2'd0)) begin bad++; $display("FAIL double_fwd_a got %0d want %0d", seen_a(3), FWD ? 1 : 0); end
        if (hz.stall_cnt !== CNT_W'(FWD ? 0 : 2)) begin bad++; $display("FAIL double_stall_cnt got %0d want %0d", hz.stall_cnt, FWD ? 0 : 2); end
    endtask

    task automatic test_random();
        instr_t cur;
        bit redir, st, held;
        do_reset();
        cur = rnd_instr();
        for (int i = 0; i < 400; i++) begin
            redir = ($urandom_range(0, 19) == 0);
            run_cycle(cur, redir, st, held);
            if (redir) cur = nop();
            else if (!st) cur = rnd_instr();
        end
    endtask

    task automatic test_saturate_then_reset();
        bit st, held;
        do_reset();
        prog.delete();
        for (int i = 0; i < 20; i++) begin
            prog.push_back(mk(2 * i + 1, 7, 1, 1, 0, 1, 0, 0));
            prog.push_back(mk(2 * i + 2, 8, 1, 0, 7, 1, 0, 1));
        end
        run_prog(95);
        total += 1;
        if (hz.stall_cnt !== CNT_W'(CMAX)) begin bad++; $display("FAIL sat_stall_cnt got %0d want %0d", hz.stall_cnt, CMAX); end
        run_cycle(mk(50, 7, 1, 1, 0, 1, 0, 0), 1'b0, st, held);
        drive_id(mk(51, 8, 1, 0, 7, 1, 0, 1), 1'b0);
        #1;
        total += 1;
        if (hz.pc_hold !== 1'b1) begin bad++; $display("FAIL pre_rst_hold got %b want 1", hz.pc_hold); end
        cpu_rst = 1'b1;
        hz.ex_redirect = 1'b1;
        #1;
        total += 1;
        if ({hz.pc_hold, hz.if_id_flush, hz.id_ex_bubble} !== 3'b0) begin
            bad++; $display("FAIL rst_prio got %b want 000", {hz.pc_hold, hz.if_id_flush, hz.id_ex_bubble});
        end
        @(posedge cpu_clk);
        #1;
        cpu_rst = 1'b0;
        hz.ex_redirect = 1'b0;
        #1;
        total += 5;
        if ({hz.pc_hold, hz.if_id_hold, hz.if_id_flush, hz.id_ex_bubble} !== 4'b0) begin
            bad++; $display("FAIL post_rst_ctl got %b want 0000", {hz.pc_hold, hz.if_id_hold, hz.if_id_flush, hz.id_ex_bubble});
        end
        if ({hz.ex_fwd_a, hz.ex_fwd_b} !== 4'b0) begin bad++; $display("FAIL post_rst_fwd got %b want 0000", {hz.ex_fwd_a, hz.ex_fwd_b}); end
        if (hz.wb_valid !== 1'b0) begin bad++; $display("FAIL post_rst_wb_valid got %b want 0", hz.wb_valid); end
        if (hz.stall_cnt !== '0) begin bad++; $display("FAIL post_rst_stall_cnt got %0d want 0", hz.stall_cnt); end
        if (hz.flush_cnt !== '0) begin bad++; $display("FAIL post_rst_flush_cnt got %0d want 0", hz.flush_cnt); end
        drive_id(nop(), 1'b0);
    endtask

    initial begin
        drive_id(nop(), 1'b0);
        model_clear();
        test_reset();
        test_raw_alu();
        test_load_use();
        test_x0_and_unused();
        test_redirect_over_stall();
        test_double_match();
        test_random();
        test_saturate_then_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
